// File: rtl/cla_pipe_addsub_if.sv
// Operand/result bus for cla_pipe_addsub.
// Purpose: groups the upstream (operand) and downstream (result) handshake
// and data signals so the adder can be bound with a single port.
//   slave  : the adder side (consumes operands, produces results)
//   master : the environment side (produces operands, consumes results)
// Signals:
//   valid_in/ready_out   operand beat handshake (a_in, b_in, c_in, op_in)
//   valid_out/ready_in   result beat handshake (sum_out, c_out, ovf_out, zero_out)
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             op_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;
  logic             ovf_out;
  logic             zero_out;

  modport slave (
    input  valid_in, a_in, b_in, c_in, op_in, ready_in,
    output ready_out, valid_out, sum_out, c_out, ovf_out, zero_out
  );

  modport master (
    output valid_in, a_in, b_in, c_in, op_in, ready_in,
    input  ready_out, valid_out, sum_out, c_out, ovf_out, zero_out
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// Purpose: WIDTH-bit A+B+c_in or A-B built from 4-bit CLA groups; the
// group-to-group carry chain is cut into STAGES register slices so wide
// add/sub closes timing. Produces carry, signed overflow and zero flags.
// Ports:
//   clk_in    rising-edge clock
//   rst_n_in  asynchronous active-low reset
//   bus       cla_pipe_addsub_if.slave (operand and result handshakes)
// Handshake: a beat moves into a slice on a clock edge when the slice's
// input is valid and the slice is ready. A slice is ready when it is empty
// or its content leaves this same edge; leaving the last slice needs
// ready_in. ready_out is the ready of slice 0, so it depends
// combinationally on ready_in and on the occupancy of every slice (any
// empty slice downstream collapses the bubble). Data and valids hold while
// a slice is not ready, so a stalled result stays stable.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  cla_pipe_addsub_if.slave  bus
);
  localparam int G   = WIDTH / 4;
  localparam int GPS = (G + STAGES - 1) / STAGES;

  // One slice's content: operands (b already conditioned), low sum bits
  // finished so far, carry into the next group, and carry into the MSB of
  // the most recently processed group (becomes the MSB carry-in at the end).
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             m;
  } slice_t;

  // 4-bit CLA group: returns {carry_out, carry_into_bit3, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       gg;
    logic       pp;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    return {gg | (pp & cin), c[3], p ^ c};
  endfunction

  // Process groups [lo, hi) in order; an empty range passes x through.
  function automatic slice_t run_groups(input slice_t x, input int lo, input int hi);
    slice_t     r;
    logic [5:0] grp;
    r   = x;
    grp = '0;
    for (int g = 0; g < G; g++) begin
      if (g >= lo && g < hi) begin
        grp              = cla4(r.a[4*g +: 4], r.b[4*g +: 4], r.c);
        r.s[4*g +: 4]    = grp[3:0];
        r.m              = grp[4];
        r.c              = grp[5];
      end
    end
    return r;
  endfunction

  function automatic int stage_hi(input int k);
    int h;
    h = (k + 1) * GPS;
    return (h > G) ? G : h;
  endfunction

  slice_t              st_q [STAGES];
  slice_t              st_o [STAGES];
  slice_t              st_in0;
  logic [STAGES-1:0]   v_q;
  logic [STAGES-1:0]   in_v;
  logic [STAGES-1:0]   rdy;
  logic                ovf_q;
  logic                zero_q;
  logic                fl_ovf;
  logic                fl_zero;

  // Operand conditioning: subtraction is A + ~B + 1, c_in ignored.
  always_comb begin
    st_in0   = '0;
    st_in0.a = bus.a_in;
    st_in0.b = bus.op_in ? ~bus.b_in : bus.b_in;
    st_in0.c = bus.op_in | bus.c_in;
  end

  always_comb begin
    st_o[0] = run_groups(st_in0, 0, stage_hi(0));
    for (int k = 1; k < STAGES; k++) begin
      st_o[k] = run_groups(st_q[k-1], k * GPS, stage_hi(k));
    end
  end

  always_comb begin
    in_v[0] = bus.valid_in;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = v_q[k-1];
    end
  end

  // Slice k is ready if ready_in is high or any slice from k onward is
  // empty: the whole tail then shifts by one and frees slice k.
  always_comb begin
    logic any_empty;
    any_empty = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      any_empty = 1'b0;
      for (int j = k; j < STAGES; j++) begin
        any_empty = any_empty | ~v_q[j];
      end
      rdy[k] = bus.ready_in | any_empty;
    end
  end

  // Flags from the fully resolved result entering the last slice.
  always_comb begin
    fl_ovf  = st_o[STAGES-1].m ^ st_o[STAGES-1].c;
    fl_zero = ~|st_o[STAGES-1].s;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k] <= in_v[k];
          if (in_v[k]) begin
            st_q[k] <= st_o[k];
          end
        end
      end
      if (rdy[STAGES-1] && in_v[STAGES-1]) begin
        ovf_q  <= fl_ovf;
        zero_q <= fl_zero;
      end
    end
  end

  assign bus.ready_out = rdy[0];
  assign bus.valid_out = v_q[STAGES-1];
  assign bus.sum_out   = st_q[STAGES-1].s;
  assign bus.c_out     = st_q[STAGES-1].c;
  assign bus.ovf_out   = ovf_q;
  assign bus.zero_out  = zero_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: 32-bit/2-slice instance for directed,
// streaming, backpressure and reset tests; two 8-bit instances
// (1 and 2 slices) for an exhaustive operand sweep.
module tb_cla_pipe_addsub;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int RW = W + 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  cla_pipe_addsub_if #(.WIDTH(W)) bus32 ();
  cla_pipe_addsub_if #(.WIDTH(8)) bus8a ();
  cla_pipe_addsub_if #(.WIDTH(8)) bus8b ();

  cla_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus32.slave));
  cla_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8_s1 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus8a.slave));
  cla_pipe_addsub #(.WIDTH(8), .STAGES(2)) dut8_s2 (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus8b.slave));

  // Observed result words {zero, ovf, c, sum}.
  logic [RW-1:0] obs32;
  logic [10:0]   obs8a;
  logic [10:0]   obs8b;
  assign obs32 = {bus32.zero_out, bus32.ovf_out, bus32.c_out, bus32.sum_out};
  assign obs8a = {bus8a.zero_out, bus8a.ovf_out, bus8a.c_out, bus8a.sum_out};
  assign obs8b = {bus8b.zero_out, bus8b.ovf_out, bus8b.c_out, bus8b.sum_out};

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [10:0]   exp8a_q[$];
  logic [10:0]   exp8b_q[$];

  function automatic logic [RW-1:0] model32(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input logic op);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         ov;
    be = op ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + (op ? 33'd1 : {32'd0, c});
    ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return {(t[W-1:0] == '0), ov, t[W], t[W-1:0]};
  endfunction

  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic op);
    logic [7:0] be;
    logic [8:0] t;
    logic       ov;
    be = op ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + (op ? 9'd1 : {8'd0, c});
    ov = (a[7] == be[7]) && (t[7] != a[7]);
    return {(t[7:0] == 8'd0), ov, t[8], t[7:0]};
  endfunction

  // Directed vectors, expected {zero, ovf, c, sum} worked out by hand.
  logic [W-1:0]  dv_a [9] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h7FFF_FFFF,
                              32'h1234_5678, 32'h0000_FFFF, 32'h0000_1234, 32'hFFFF_FFFF,
                              32'h7FFF_FFFF};
  logic [W-1:0]  dv_b [9] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001,
                              32'h1111_1111, 32'h0000_0001, 32'h0000_1234, 32'h0000_0000,
                              32'hFFFF_FFFF};
  logic          dv_c [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic          dv_op[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [RW-1:0] dv_e [9] = '{{3'b101, 32'h0000_0000}, {3'b011, 32'h7FFF_FFFF},
                              {3'b000, 32'hFFFF_FFFE}, {3'b010, 32'h8000_0000},
                              {3'b000, 32'h2345_678A}, {3'b000, 32'h0001_0000},
                              {3'b101, 32'h0000_0000}, {3'b101, 32'h0000_0000},
                              {3'b010, 32'h8000_0000}};

  // ---------------- driver tasks ----------------
  // Send one beat into an empty pipe with ready_in=1; report whether it was
  // accepted, how many cycles until valid_out, and the result word.
  task automatic send_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             input logic op, output logic acc, output int lat,
                             output logic [RW-1:0] got);
    @(negedge clk);
    bus32.ready_in = 1'b1;
    bus32.valid_in = 1'b1;
    bus32.a_in     = a;
    bus32.b_in     = b;
    bus32.c_in     = c;
    bus32.op_in    = op;
    #1;
    acc = bus32.ready_out;
    @(posedge clk);
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
      bus32.valid_in = 1'b0;
      #1;
    end while (!bus32.valid_out && lat < 20);
    got = obs32;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++; if (bus32.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out got=%b exp=0", bus32.valid_out); end
    checks++; if (bus32.sum_out !== '0) begin failures++; $display("FAIL reset_sum_out got=%h exp=0", bus32.sum_out); end
    checks++; if (bus32.c_out !== 1'b0) begin failures++; $display("FAIL reset_c_out got=%b exp=0", bus32.c_out); end
    checks++; if (bus32.ovf_out !== 1'b0) begin failures++; $display("FAIL reset_ovf_out got=%b exp=0", bus32.ovf_out); end
    checks++; if (bus32.zero_out !== 1'b0) begin failures++; $display("FAIL reset_zero_out got=%b exp=0", bus32.zero_out); end
    checks++; if (bus32.ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready_out got=%b exp=1", bus32.ready_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic          acc;
    int            lat;
    logic [RW-1:0] got;
    for (int i = 0; i < 9; i++) begin
      send_single(dv_a[i], dv_b[i], dv_c[i], dv_op[i], acc, lat, got);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL directed%0d_accept got=%b exp=1", i, acc); end
      checks++; if (lat != S) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, S); end
      checks++; if (got !== dv_e[i]) begin failures++; $display("FAIL directed%0d_result got=%h exp=%h", i, got, dv_e[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [RW-1:0] e;
    int            idx = 0;
    int            got_n = 0;
    int            cyc = 0;
    exp_q.delete();
    while (got_n < 6 && cyc < 40) begin
      @(negedge clk);
      bus32.ready_in = 1'b1;
      bus32.valid_in = (idx < 6);
      bus32.a_in     = 32'h0101_0101 * (idx + 1);
      bus32.b_in     = 32'hF0F0_F0F0 + idx;
      bus32.c_in     = idx[0];
      bus32.op_in    = idx[1];
      #1;
      checks++; if (bus32.ready_out !== 1'b1) begin failures++; $display("FAIL b2b_ready_out cyc=%0d got=%b exp=1", cyc, bus32.ready_out); end
      if (bus32.valid_out && bus32.ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_unexpected got=%h exp=none", obs32); end
        else begin
          e = exp_q.pop_front();
          if (obs32 !== e) begin failures++; $display("FAIL b2b_result got=%h exp=%h", obs32, e); end
        end
        got_n++;
      end
      if (bus32.valid_in && bus32.ready_out) begin
        exp_q.push_back(model32(bus32.a_in, bus32.b_in, bus32.c_in, bus32.op_in));
        idx++;
      end
      cyc++;
    end
    bus32.valid_in = 1'b0;
    checks++; if (cyc != 6 + S) begin failures++; $display("FAIL b2b_throughput got=%0d exp=%0d", cyc, 6 + S); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0]  ba [8];
    logic [W-1:0]  bb [8];
    logic          bc [8];
    logic          bo [8];
    logic [RW-1:0] e;
    logic [RW-1:0] prev_obs = '0;
    logic          prev_stall = 1'b0;
    int            idx = 0;
    int            got_n = 0;
    int            held = 0;
    int            cyc = 0;
    for (int i = 0; i < 8; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
      bc[i] = 1'($urandom_range(0, 1));
      bo[i] = 1'($urandom_range(0, 1));
    end
    exp_q.delete();
    while (got_n < 8 && cyc < 200) begin
      @(negedge clk);
      bus32.ready_in = cyc[0];
      bus32.valid_in = (idx < 8);
      if (idx < 8) begin
        bus32.a_in  = ba[idx];
        bus32.b_in  = bb[idx];
        bus32.c_in  = bc[idx];
        bus32.op_in = bo[idx];
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (obs32 !== prev_obs || bus32.valid_out !== 1'b1) begin
          failures++; $display("FAIL bp_stall_hold cyc=%0d got=%h exp=%h", cyc, obs32, prev_obs);
        end
      end
      checks++;
      if (held == S && !bus32.ready_in) begin
        if (bus32.ready_out !== 1'b0) begin failures++; $display("FAIL bp_ready_full cyc=%0d got=%b exp=0", cyc, bus32.ready_out); end
      end else begin
        if (bus32.ready_out !== 1'b1) begin failures++; $display("FAIL bp_ready_free cyc=%0d got=%b exp=1", cyc, bus32.ready_out); end
      end
      if (bus32.valid_out && bus32.ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_unexpected got=%h exp=none", obs32); end
        else begin
          e = exp_q.pop_front();
          if (obs32 !== e) begin failures++; $display("FAIL bp_result n=%0d got=%h exp=%h", got_n, obs32, e); end
        end
        got_n++;
        held--;
      end
      if (bus32.valid_in && bus32.ready_out) begin
        exp_q.push_back(model32(ba[idx], bb[idx], bc[idx], bo[idx]));
        idx++;
        held++;
      end
      prev_stall = bus32.valid_out && !bus32.ready_in;
      prev_obs   = obs32;
      cyc++;
    end
    bus32.valid_in = 1'b0;
    bus32.ready_in = 1'b1;
    checks++; if (got_n != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_n); end
  endtask

  task automatic test_reset_midflight;
    logic          acc;
    int            lat;
    logic [RW-1:0] got;
    @(negedge clk);
    bus32.ready_in = 1'b1;
    bus32.valid_in = 1'b1;
    bus32.a_in = 32'h1111_1111; bus32.b_in = 32'h2222_2222; bus32.c_in = 1'b0; bus32.op_in = 1'b0;
    @(negedge clk);
    bus32.a_in = 32'h3333_3333; bus32.b_in = 32'h0000_0001; bus32.c_in = 1'b0; bus32.op_in = 1'b1;
    @(negedge clk);
    bus32.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus32.valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_valid_out got=%b exp=0", bus32.valid_out); end
    checks++; if (bus32.sum_out !== '0) begin failures++; $display("FAIL rstmid_sum_out got=%h exp=0", bus32.sum_out); end
    checks++; if (bus32.c_out !== 1'b0) begin failures++; $display("FAIL rstmid_c_out got=%b exp=0", bus32.c_out); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus32.valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", i, bus32.valid_out); end
    end
    send_single(32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b0, acc, lat, got);
    checks++; if (lat != S) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, S); end
    checks++; if (got !== {3'b000, 32'hA5A5_5A5A}) begin failures++; $display("FAIL rstmid_first got=%h exp=%h", got, {3'b000, 32'hA5A5_5A5A}); end
  endtask

  // Exhaustive 8-bit operands into the 1-slice and 2-slice instances in
  // parallel, one beat per cycle, random c_in/op per beat.
  task automatic test_sweep;
    logic [10:0] e;
    logic        c;
    logic        op;
    exp8a_q.delete();
    exp8b_q.delete();
    for (int n = 0; n < 65536 + 4; n++) begin
      @(negedge clk);
      c  = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      bus8a.ready_in = 1'b1; bus8b.ready_in = 1'b1;
      bus8a.valid_in = (n < 65536); bus8b.valid_in = (n < 65536);
      bus8a.a_in = n[15:8]; bus8b.a_in = n[15:8];
      bus8a.b_in = n[7:0];  bus8b.b_in = n[7:0];
      bus8a.c_in = c;       bus8b.c_in = c;
      bus8a.op_in = op;     bus8b.op_in = op;
      #1;
      if (bus8a.valid_out) begin
        checks++;
        if (exp8a_q.size() == 0) begin failures++; $display("FAIL sweep_s1_unexpected got=%h exp=none", obs8a); end
        else begin
          e = exp8a_q.pop_front();
          if (obs8a !== e) begin failures++; $display("FAIL sweep_s1_result n=%0d got=%h exp=%h", n, obs8a, e); end
        end
      end
      if (bus8b.valid_out) begin
        checks++;
        if (exp8b_q.size() == 0) begin failures++; $display("FAIL sweep_s2_unexpected got=%h exp=none", obs8b); end
        else begin
          e = exp8b_q.pop_front();
          if (obs8b !== e) begin failures++; $display("FAIL sweep_s2_result n=%0d got=%h exp=%h", n, obs8b, e); end
        end
      end
      if (n < 65536) begin
        checks++; if (bus8a.ready_out !== 1'b1) begin failures++; $display("FAIL sweep_s1_ready n=%0d got=%b exp=1", n, bus8a.ready_out); end
        checks++; if (bus8b.ready_out !== 1'b1) begin failures++; $display("FAIL sweep_s2_ready n=%0d got=%b exp=1", n, bus8b.ready_out); end
        if (bus8a.ready_out) exp8a_q.push_back(model8(n[15:8], n[7:0], c, op));
        if (bus8b.ready_out) exp8b_q.push_back(model8(n[15:8], n[7:0], c, op));
      end
    end
    bus8a.valid_in = 1'b0;
    bus8b.valid_in = 1'b0;
    checks++; if (exp8a_q.size() != 0) begin failures++; $display("FAIL sweep_s1_drain got=%0d exp=0", exp8a_q.size()); end
    checks++; if (exp8b_q.size() != 0) begin failures++; $display("FAIL sweep_s2_drain got=%0d exp=0", exp8b_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus32.valid_in = 1'b0; bus32.ready_in = 1'b0; bus32.a_in = '0; bus32.b_in = '0;
    bus32.c_in = 1'b0; bus32.op_in = 1'b0;
    bus8a.valid_in = 1'b0; bus8a.ready_in = 1'b0; bus8a.a_in = '0; bus8a.b_in = '0;
    bus8a.c_in = 1'b0; bus8a.op_in = 1'b0;
    bus8b.valid_in = 1'b0; bus8b.ready_in = 1'b0; bus8b.a_in = '0; bus8b.b_in = '0;
    bus8b.c_in = 1'b0; bus8b.op_in = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
